// File: rtl/snes_header_detect_if.sv
// ioctl download bus from hps_io towards the header detector.
//   ioctl_download : high while a ROM image is streamed
//   ioctl_wr       : one-cycle word strobe
//   ioctl_addr     : even byte address of the word
//   ioctl_dout     : [7:0] byte at addr, [15:8] byte at addr+1
interface snes_header_detect_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;

  modport master (output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
  modport slave  (input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/snes_header_detect.sv
// SNES cartridge header analyser on the ROM download path.
// Captures the Lo/Hi/ExHi internal header candidates (with and without a
// 512-byte copier header) while the image streams in, scores them after the
// download ends and publishes mapping type, ROM/RAM masks and video region.
//   clk_sys, reset : system clock, synchronous active-high reset
//   ioctl          : download bus (slave side)
//   force_type     : 0 auto, 1 no header, 2 Lo, 3 Hi, 4 ExHi, 5-7 auto
//   rom_type       : [3:0] map code (0/1/5), [7:4] upper nibble of FD6
//   rom_mask       : ROM address mask
//   ram_mask       : backup RAM address mask, 0 when none
//   rom_region     : 1 = PAL
//   valid          : outputs describe the last completed download
module snes_header_detect #(
  parameter logic [24:0] EXHI_MIN_BYTES = 25'h400001
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  snes_header_detect_if.slave  ioctl,
  input  logic [2:0]           force_type,
  output logic [7:0]           rom_type,
  output logic [23:0]          rom_mask,
  output logic [23:0]          ram_mask,
  output logic                 rom_region,
  output logic                 valid
);
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SCORE0, S_SCORE1, S_SCORE2, S_COMMIT} state_t;

  // Slot index = {candidate[1:0], copier_offset}
  logic [3:0]  r_mode   [6];
  logic [3:0]  r_thi    [6];
  logic [7:0]  r_romsz  [6];
  logic [7:0]  r_ramsz  [6];
  logic [7:0]  r_region [6];
  logic [15:0] r_cmpl   [6];
  logic [15:0] r_csum   [6];

  state_t      r_state;
  logic        r_dl, r_dl2;
  logic [24:0] r_count;
  logic [1:0]  r_best;
  logic [2:0]  r_bscore;

  function automatic logic [3:0] map_code(input logic [1:0] c);
    case (c)
      2'd0:    map_code = 4'h0;
      2'd1:    map_code = 4'h1;
      default: map_code = 4'h5;
    endcase
  endfunction

  // Headers sit in a 32-byte aligned window, so bits [24:5] identify the slot.
  function automatic logic [19:0] slot_tag(input int s);
    logic [24:0] b;
    case (s / 2)
      0:       b = 25'h0007FC0;
      1:       b = 25'h000FFC0;
      default: b = 25'h040FFC0;
    endcase
    if (s % 2 == 1) b = b + 25'h200;
    return b[24:5];
  endfunction

  function automatic logic [2:0] cand_score(input logic [1:0] c, input logic [3:0] mode,
                                            input logic [7:0] romsz, input logic [7:0] ramsz,
                                            input logic [15:0] cmpl, input logic [15:0] csum);
    logic [2:0] sc;
    sc = 3'd0;
    if ((csum ^ cmpl) == 16'hFFFF)          sc = sc + 3'd2;
    if (mode == map_code(c))                sc = sc + 3'd1;
    if (romsz >= 8'h07 && romsz <= 8'h0D)   sc = sc + 3'd1;
    if (ramsz <= 8'h07)                     sc = sc + 3'd1;
    return sc;
  endfunction

  // Rise acts on the raw input so a write in the very first cycle survives the
  // slot clear; fall uses the registered copy, giving the one-cycle edge stage.
  logic w_rise, w_fall, w_cap, w_hdr, w_exhi_ok;
  logic [5:0]  w_hit;
  logic [24:0] w_size;
  logic [3:0]  w_size_n;

  assign w_rise    = ioctl.ioctl_download & ~r_dl;
  assign w_fall    = ~r_dl & r_dl2;
  assign w_cap     = ioctl.ioctl_download & ioctl.ioctl_wr & (w_rise | (r_state == S_CAPTURE));
  assign w_hdr     = (r_count[9:0] == 10'h200);
  assign w_size    = r_count - (w_hdr ? 25'h200 : 25'h0);
  assign w_exhi_ok = (w_size >= EXHI_MIN_BYTES);

  always_comb begin
    w_hit = '0;
    for (int s = 0; s < 6; s++) w_hit[s] = (ioctl.ioctl_addr[24:5] == slot_tag(s));
  end

  // Smallest n with (1024 << n) >= size, saturating at 13.
  always_comb begin
    w_size_n = 4'd13;
    for (int n = 13; n >= 0; n--)
      if ((25'd1024 << n) >= w_size) w_size_n = 4'(n);
  end

  // Scoring: one candidate per SCORE state, taken from the copier-selected copy.
  logic [1:0] w_sc_cand;
  logic [2:0] w_sc_idx, w_score;
  always_comb begin
    case (r_state)
      S_SCORE1: w_sc_cand = 2'd1;
      S_SCORE2: w_sc_cand = 2'd2;
      default:  w_sc_cand = 2'd0;
    endcase
    w_sc_idx = {w_sc_cand, w_hdr};
    w_score  = cand_score(w_sc_cand, r_mode[w_sc_idx], r_romsz[w_sc_idx], r_ramsz[w_sc_idx],
                          r_cmpl[w_sc_idx], r_csum[w_sc_idx]);
    if (w_sc_cand == 2'd2 && !w_exhi_ok) w_score = 3'd0;
  end

  // Field mapping for the winning candidate.
  logic [1:0]  w_win;
  logic [2:0]  w_cidx, w_ram_sz;
  logic [3:0]  w_rom_sz;
  logic [7:0]  w_romsz, w_ramsz, w_rgn, w_type;
  logic [23:0] w_rom_mask, w_ram_mask;
  logic        w_noh, w_pal;
  always_comb begin
    w_noh = (force_type == 3'd1);
    case (force_type)
      3'd2:    w_win = 2'd0;
      3'd3:    w_win = 2'd1;
      3'd4:    w_win = 2'd2;
      default: w_win = r_best;
    endcase
    w_cidx     = {w_win, w_hdr};
    w_romsz    = r_romsz[w_cidx];
    w_ramsz    = r_ramsz[w_cidx];
    w_rgn      = r_region[w_cidx];
    w_rom_sz   = (!w_noh && w_romsz >= 8'h07 && w_romsz <= 8'h0D) ? w_romsz[3:0] : w_size_n;
    w_ram_sz   = (w_ramsz > 8'h07) ? 3'd7 : w_ramsz[2:0];
    w_rom_mask = (24'd1024 << w_rom_sz) - 24'd1;
    w_ram_mask = (w_noh || w_ramsz == 8'h00) ? 24'h0 : (24'd1024 << w_ram_sz) - 24'd1;
    w_pal      = !w_noh && ((w_rgn >= 8'h02 && w_rgn <= 8'h0C) || w_rgn == 8'h11 || w_rgn == 8'h12);
    w_type     = w_noh ? 8'h00 : {r_thi[w_cidx], map_code(w_win)};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      // Start "high" so a download already in progress is not picked up mid-way.
      r_dl       <= 1'b1;
      r_dl2      <= 1'b1;
      r_count    <= '0;
      r_best     <= '0;
      r_bscore   <= '0;
      rom_type   <= 8'h00;
      rom_mask   <= 24'h3FFFFF;
      ram_mask   <= 24'h0;
      rom_region <= 1'b0;
      valid      <= 1'b0;
      for (int s = 0; s < 6; s++) begin
        r_mode[s] <= '0; r_thi[s] <= '0; r_romsz[s] <= '0; r_ramsz[s] <= '0;
        r_region[s] <= '0; r_cmpl[s] <= '0; r_csum[s] <= '0;
      end
    end else begin
      r_dl  <= ioctl.ioctl_download;
      r_dl2 <= r_dl;
      if (w_rise) begin
        // New download (or abort of a pending analysis): start from clean slots.
        r_state <= S_CAPTURE;
        r_count <= '0;
        valid   <= 1'b0;
        for (int s = 0; s < 6; s++) begin
          r_mode[s] <= '0; r_thi[s] <= '0; r_romsz[s] <= '0; r_ramsz[s] <= '0;
          r_region[s] <= '0; r_cmpl[s] <= '0; r_csum[s] <= '0;
        end
      end else begin
        case (r_state)
          S_CAPTURE: if (w_fall) r_state <= S_SCORE0;
          S_SCORE0: begin
            r_best   <= 2'd0;
            r_bscore <= w_score;
            r_state  <= S_SCORE1;
          end
          S_SCORE1: begin
            if (w_score > r_bscore) begin r_best <= 2'd1; r_bscore <= w_score; end
            r_state <= S_SCORE2;
          end
          S_SCORE2: begin
            if (w_score > r_bscore) begin r_best <= 2'd2; r_bscore <= w_score; end
            r_state <= S_COMMIT;
          end
          S_COMMIT: begin
            rom_type   <= w_type;
            rom_mask   <= w_rom_mask;
            ram_mask   <= w_ram_mask;
            rom_region <= w_pal;
            valid      <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
      // Placed after the clear so a write on the start cycle is kept.
      if (w_cap) begin
        r_count <= ioctl.ioctl_addr + 25'd2;
        for (int s = 0; s < 6; s++) begin
          if (w_hit[s]) begin
            case (ioctl.ioctl_addr[4:0])
              5'h14: r_mode[s] <= ioctl.ioctl_dout[11:8];
              5'h16: begin r_thi[s] <= ioctl.ioctl_dout[7:4]; r_romsz[s] <= ioctl.ioctl_dout[15:8]; end
              5'h18: begin r_ramsz[s] <= ioctl.ioctl_dout[7:0]; r_region[s] <= ioctl.ioctl_dout[15:8]; end
              5'h1C: r_cmpl[s] <= ioctl.ioctl_dout;
              5'h1E: r_csum[s] <= ioctl.ioctl_dout;
              default: ;
            endcase
          end
        end
      end
    end
  end
endmodule
